// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and encodings for the ID/EX hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam int MD_TIMEOUT_DEF = 40;
    localparam int CNT_W_DEF      = 32;

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - EX operand forwarding select for one source register
import pipe_ctrl_pkg::*;

module hazard_fwd_sel (
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] sel
);

    // MEM holds the younger value, so it wins over WB; x0 is never forwarded.
    always_comb begin
        sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush, forwarding and DIV/REM hold control
import pipe_ctrl_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int         MD_TIMEOUT = MD_TIMEOUT_DEF,
    parameter int         CNT_W      = CNT_W_DEF,
    parameter logic [1:0] RS_LOAD    = RESULT_SRC_LOAD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MdDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MdBusy,
    output logic             MdErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 1);

    state_t              state;
    logic [MD_CNT_W-1:0] md_cnt;
    logic                lw_stall;
    logic                md_hold;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;

    hazard_fwd_sel u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b)
    );

    // The DIV is held only while no result has arrived and the timeout is not yet reached.
    always_comb begin
        lw_stall = (ResultSrcE == RS_LOAD) && (RdE != 5'd0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
        md_hold  = (state == MD_BUSY) && !MdDoneE &&
                   (md_cnt != MD_CNT_W'(MD_TIMEOUT));
    end

    // Gating with rst makes every control drop as soon as reset is asserted.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        MdBusy    = 1'b0;
        if (rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            MdBusy    = (state == MD_BUSY);
            if (state == RUN) begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
            end else begin
                StallF = md_hold;
                StallD = md_hold;
                StallE = md_hold;
                FlushM = md_hold;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            md_cnt      <= '0;
            MdErr       <= 1'b0;
            StallCycles <= '0;
        end else begin
            if (StallF && (StallCycles != {CNT_W{1'b1}})) begin
                StallCycles <= StallCycles + 1'b1;
            end
            case (state)
                RUN: begin
                    if (MdStartE && !MdDoneE) begin
                        state  <= MD_BUSY;
                        md_cnt <= MD_CNT_W'(1);
                    end
                end
                MD_BUSY: begin
                    if (MdDoneE) begin
                        state  <= RUN;
                        md_cnt <= '0;
                    end else if (md_cnt == MD_CNT_W'(MD_TIMEOUT)) begin
                        state  <= RUN;
                        md_cnt <= '0;
                        MdErr  <= 1'b1;
                    end else begin
                        md_cnt <= md_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= RUN;
                    md_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CW = 8;

    typedef struct {
        string         tag;
        logic [11:0]   ctl;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, PCSrcE, MdStartE, MdDoneE;
    logic          StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          MdBusy, MdErr;
    logic [CW-1:0] StallCycles;

    exp_t          exp_q[$];
    logic [CW-1:0] exp_cnt = '0;
    int            n_assert = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MdStartE(MdStartE), .MdDoneE(MdDoneE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdBusy(MdBusy), .MdErr(MdErr), .StallCycles(StallCycles)
    );

    function automatic logic [11:0] mk(input logic sf, input logic sd, input logic se,
                                       input logic fd, input logic fe, input logic fm,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic busy, input logic err);
        return {sf, sd, se, fd, fe, fm, fa, fb, busy, err};
    endfunction

    task automatic chk();
        exp_t        e;
        logic [11:0] obs;
        e   = exp_q.pop_front();
        obs = {StallF, StallD, StallE, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, MdBusy, MdErr};
        n_assert++;
        assert (obs === e.ctl) else begin
            n_fail++;
            $error("FAIL %s ctl observed=%b expected=%b", e.tag, obs, e.ctl);
        end
        n_assert++;
        assert (StallCycles === e.cnt) else begin
            n_fail++;
            $error("FAIL %s StallCycles observed=%0d expected=%0d", e.tag, StallCycles, e.cnt);
        end
    endtask

    // Called at posedge+1: sample at the following negedge, then advance past the next edge.
    task automatic step(input string tag, input logic [11:0] e);
        exp_q.push_back('{tag, e, exp_cnt});
        @(negedge clk);
        chk();
        @(posedge clk);
        if (e[11] && rst && (exp_cnt != {CW{1'b1}})) exp_cnt = exp_cnt + 1'b1;
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; MdStartE = 0; MdDoneE = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1'b0;
        // Active-looking inputs during reset must all be masked.
        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; PCSrcE = 1; MdStartE = 1;
        RegWriteM = 1; RdM = 7; Rs1E = 7;
        @(posedge clk); #1;
        step("reset", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        rst = 1'b1;
        idle_inputs();
        step("idle", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));

        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        step("lw_rs1", mk(1,1,0,0,1,0,2'b00,2'b00,0,0));
        Rs1D = 3; Rs2D = 5;
        step("lw_rs2", mk(1,1,0,0,1,0,2'b00,2'b00,0,0));
        RdE = 0; Rs1D = 0; Rs2D = 0;
        step("lw_rd0", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        ResultSrcE = 2'b00; RdE = 5; Rs1D = 5;
        step("alu_no_stall", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        idle_inputs();

        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7;
        step("fwd_a_mem", mk(0,0,0,0,0,0,2'b10,2'b00,0,0));
        RegWriteM = 0;
        step("fwd_a_wb", mk(0,0,0,0,0,0,2'b01,2'b00,0,0));
        RegWriteM = 1; Rs1E = 4; Rs2E = 7;
        step("fwd_b_mem", mk(0,0,0,0,0,0,2'b00,2'b10,0,0));
        RdM = 0; Rs1E = 0; Rs2E = 7;
        step("fwd_rdm0", mk(0,0,0,0,0,0,2'b00,2'b01,0,0));
        RdW = 0; Rs2E = 0;
        step("fwd_x0", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        idle_inputs();

        PCSrcE = 1;
        step("branch", mk(0,0,0,1,1,0,2'b00,2'b00,0,0));
        ResultSrcE = 2'b01; RdE = 6; Rs2D = 6;
        step("lw_and_branch", mk(1,1,0,1,1,0,2'b00,2'b00,0,0));
        idle_inputs();

        MdStartE = 1; MdDoneE = 1;
        step("md_single", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        MdStartE = 0; MdDoneE = 0;
        step("md_single_run", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));

        MdStartE = 1;
        step("md_start", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        for (int i = 0; i < 33; i++) begin
            if (i == 10) begin
                ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; PCSrcE = 1;
            end else begin
                ResultSrcE = 2'b00; RdE = 0; Rs1D = 0; PCSrcE = 0;
            end
            step("md_busy", mk(1,1,1,0,0,1,2'b00,2'b00,1,0));
        end
        idle_inputs();
        MdDoneE = 1;
        step("md_done", mk(0,0,0,0,0,0,2'b00,2'b00,1,0));
        MdDoneE = 0;
        step("md_after", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));

        MdStartE = 1;
        step("to_start", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));
        for (int i = 0; i < 39; i++) begin
            step("to_busy", mk(1,1,1,0,0,1,2'b00,2'b00,1,0));
        end
        MdStartE = 0;
        step("to_release", mk(0,0,0,0,0,0,2'b00,2'b00,1,0));
        step("to_err", mk(0,0,0,0,0,0,2'b00,2'b00,0,1));
        step("to_sticky", mk(0,0,0,0,0,0,2'b00,2'b00,0,1));

        ResultSrcE = 2'b01; RdE = 9; Rs2D = 9;
        for (int i = 0; i < 200; i++) begin
            step("sat", mk(1,1,0,0,1,0,2'b00,2'b00,0,1));
        end
        idle_inputs();
        step("sat_hold", mk(0,0,0,0,0,0,2'b00,2'b00,0,1));

        MdStartE = 1;
        step("rst_md_start", mk(0,0,0,0,0,0,2'b00,2'b00,0,1));
        for (int i = 0; i < 5; i++) begin
            step("rst_md_busy", mk(1,1,1,0,0,1,2'b00,2'b00,1,1));
        end
        #2;
        rst = 1'b0;
        exp_cnt = '0;
        #1;
        exp_q.push_back('{"rst_mid_busy", mk(0,0,0,0,0,0,2'b00,2'b00,0,0), exp_cnt});
        chk();
        @(posedge clk); #1;
        rst = 1'b1;
        MdStartE = 0;
        step("post_rst", mk(0,0,0,0,0,0,2'b00,2'b00,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
